// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: immediate extension modes and default widths.
package cpu_defs;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: widens an IN_W-bit field to OUT_W bits
// in zero, sign, upper-load or branch-offset form.
module imm_extend_core
    import cpu_defs::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] ext
);

    // Branch offsets are shifted by two, so two headroom bits are needed above
    // the sign-extended field for no significant bit to be lost.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_core: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){data[IN_W-1]}}, data};

    // Select the extension form for the requested mode.
    always_comb begin
        ext = '0;
        case (mode)
            EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, data};
            EXT_SIGN:   ext = sext;
            EXT_UPPER:  ext = {data, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: ext = sext << 2;
            default:    ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake, a
// two-entry (main + skid) buffer and synchronous flush. Entries hold the
// already-extended word, so the mode is not carried through the buffer.
module imm_extend_stage
    import cpu_defs::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext_out
);

    logic [OUT_W-1:0] ext_word;
    logic [OUT_W-1:0] skid_q;
    logic             skid_valid;

    logic [OUT_W-1:0] main_n;
    logic             main_v_n;
    logic [OUT_W-1:0] skid_n;
    logic             skid_v_n;
    logic             accept;
    logic             consume;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (in_mode),
        .data (in_data),
        .ext  (ext_word)
    );

    // Next-state for main/skid; flush overrides any accept or consume.
    always_comb begin
        main_n   = ext_out;
        main_v_n = out_valid;
        skid_n   = skid_q;
        skid_v_n = skid_valid;
        accept   = in_valid && in_ready && !flush;
        consume  = out_valid && out_ready;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!out_valid || consume) begin
            if (skid_valid) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = accept;
                if (accept) begin
                    skid_n = ext_word;
                end
            end else begin
                main_v_n = accept;
                if (accept) begin
                    main_n = ext_word;
                end
            end
        end else if (accept) begin
            skid_n   = ext_word;
            skid_v_n = 1'b1;
        end
    end

    // Register the buffer state; in_ready tracks "skid will be empty".
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ext_out    <= '0;
            out_valid  <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            ext_out    <= main_n;
            out_valid  <= main_v_n;
            skid_q     <= skid_n;
            skid_valid <= skid_v_n;
            in_ready   <= !skid_v_n;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Randomised and directed bench for imm_extend_stage against a two-deep FIFO model.
module tb_imm_extend_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_out;

    logic        v_valid;
    logic        v_ready;
    logic [11:0] v_data;
    logic        v_out_valid;
    logic [15:0] v_ext;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];

    imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_out   (ext_out)
    );

    imm_extend_stage #(.IN_W(12), .OUT_W(16)) dut_small (
        .CLK       (clk),
        .RST_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (v_valid),
        .in_ready  (v_ready),
        .in_mode   (2'b11),
        .in_data   (v_data),
        .out_valid (v_out_valid),
        .out_ready (1'b1),
        .ext_out   (v_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(logic [15:0] d, logic [1:0] m);
        int s;
        s = int'($signed(d));
        case (m)
            2'd0:    return 32'(int'(d));
            2'd1:    return 32'(s);
            2'd2:    return 32'(int'(d) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: at most two results in flight, FIFO order, flush empties it.
    always @(posedge clk) begin
        logic acc, con;
        if (rst_n) begin
            acc = in_valid && (q.size() < 2) && !flush;
            con = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(ref_ext(in_data, in_mode));
            end
        end
    end

    always @(negedge rst_n) q.delete();

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_ext_out", ext_out, 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (out_valid && q.size() > 0) chk("ext_out", ext_out, q[0]);
        end
    end

    // Present an item (at a falling edge) and wait for it to be accepted.
    task automatic push(logic [15:0] d, logic [1:0] m);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1;
            @(negedge clk);
        end
        if (!done) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] sweep_exp[4];
        sweep_exp[0] = 32'h0000_8001;
        sweep_exp[1] = 32'hFFFF_8001;
        sweep_exp[2] = 32'h8001_0000;
        sweep_exp[3] = 32'hFFFE_0004;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 2'd0;
        in_data = 16'h0; out_ready = 1'b0; v_valid = 1'b0; v_data = 12'h0;

        for (int m = 0; m < 4; m++)
            chk("model_pin", ref_ext(16'h8001, 2'(m)), sweep_exp[m]);
        chk("model_pin_7fff", ref_ext(16'h7FFF, 2'd1), 32'h0000_7FFF);

        #22 rst_n = 1'b1;
        @(negedge clk);

        // Mode sweep
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            push(16'h8001, 2'(m));
            chk("sweep_valid", 32'(out_valid), 32'd1);
            chk("sweep_ext", ext_out, sweep_exp[m]);
        end
        @(negedge clk);

        // Back-pressure
        out_ready = 1'b0;
        push(16'h0001, 2'd0);
        push(16'h0002, 2'd0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 16'h0003; in_mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_ext", ext_out, 32'd1);
        end
        out_ready = 1'b1;
        push(16'h0003, 2'd0);
        repeat (3) @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming
        push(16'h7FFF, 2'd1);
        chk("stream_ext0", ext_out, 32'h0000_7FFF);
        push(16'hFFFF, 2'd1);
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_ext1", ext_out, 32'hFFFF_FFFF);
        @(negedge clk);

        // Flush with both entries full and a new item offered
        out_ready = 1'b0;
        push(16'h1111, 2'd0);
        push(16'h2222, 2'd0);
        in_valid = 1'b1; in_data = 16'h3333; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("flush_no_out", 32'(out_valid), 32'd0);

        // Flush while ready: offered item must be dropped
        out_ready = 1'b0;
        push(16'h4444, 2'd0);
        in_valid = 1'b1; in_data = 16'h5555; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Asynchronous reset while holding a result
        push(16'h00AB, 2'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ext", ext_out, 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Narrow variant: 12-bit branch offset into 16 bits
        v_valid = 1'b1; v_data = 12'h800;
        @(negedge clk);
        v_valid = 1'b0;
        chk("small_valid", 32'(v_out_valid), 32'd1);
        chk("small_ext", 32'(v_ext), 32'h0000_E000);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
